reg_alu_step_ctrl: RTL and testbench

//  Button-stepped sequencer for the register-file/ALU datapath. Debounces the

---
 rtl/reg_alu_step_ctrl.sv | 163 ++++++++++++++++
 tb/tb_reg_alu_step_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_alu_step_ctrl.sv
// reg_alu_step_ctrl
// Single-step sequencer for the register-file/ALU datapath. A debounced
// button press walks one latched 16-bit instruction through three phases:
// operand read, execute and write-back. Each step emits one registered,
// one-cycle enable pulse to the datapath.
module reg_alu_step_ctrl #(
  parameter int DEB_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      INS,
  input  logic             btn,
  output logic [3:0]       rf_ra1,
  output logic [3:0]       rf_ra2,
  output logic             opab_le,
  output logic [3:0]       alu_op,
  output logic             res_le,
  output logic [3:0]       rf_wa,
  output logic             rf_we,
  output logic [1:0]       phase,
  output logic             done,
  output logic [CNT_W-1:0] instr_cnt
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPS  = 2'd1,
    ST_EXE  = 2'd2
  } state_t;

  logic             sync1_r;
  logic             sync2_r;
  logic             clean_r;
  logic             clean_d_r;
  logic [DEB_W-1:0] deb_cnt_r;
  logic             step_s;

  state_t           state_r;
  state_t           state_nx_s;
  logic [15:0]      ir_r;
  logic [15:0]      ir_nx_s;
  logic             opab_nx_s;
  logic             res_nx_s;
  logic             we_nx_s;
  logic             done_nx_s;
  logic [CNT_W-1:0] cnt_nx_s;

  // Two-stage synchronizer for the asynchronous step button.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= btn;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: the clean level flips only after the synced button has
  // disagreed with it for DEB_CYCLES counted samples plus the flipping one,
  // which fixes the press-to-pulse latency at DEB_CYCLES+3 edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_cnt_r <= '0;
      clean_r   <= 1'b0;
      clean_d_r <= 1'b0;
    end else begin
      clean_d_r <= clean_r;
      if (sync2_r == clean_r) begin
        deb_cnt_r <= '0;
      end else if (deb_cnt_r == DEB_W'(DEB_CYCLES)) begin
        clean_r   <= sync2_r;
        deb_cnt_r <= '0;
      end else begin
        deb_cnt_r <= deb_cnt_r + DEB_W'(32'd1);
      end
    end
  end

  // Only the rising edge of the clean level is a step; release is ignored.
  assign step_s = clean_r & ~clean_d_r;

  // Next-state and next-pulse logic of the three-phase stepper.
  always_comb begin
    state_nx_s = state_r;
    ir_nx_s    = ir_r;
    opab_nx_s  = 1'b0;
    res_nx_s   = 1'b0;
    we_nx_s    = 1'b0;
    done_nx_s  = 1'b0;
    cnt_nx_s   = instr_cnt;
    case (state_r)
      ST_IDLE: begin
        if (step_s) begin
          ir_nx_s    = INS;
          state_nx_s = ST_OPS;
          opab_nx_s  = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_OPS: begin
        if (step_s) begin
          state_nx_s = ST_EXE;
          res_nx_s   = 1'b1;
        end else begin
          state_nx_s = ST_OPS;
        end
      end
      ST_EXE: begin
        if (step_s) begin
          state_nx_s = ST_IDLE;
          done_nx_s  = 1'b1;
          cnt_nx_s   = instr_cnt + CNT_W'(32'd1);
          // Opcode F is compare-only: it retires without a register write.
          if (ir_r[15:12] != 4'hF) begin
            we_nx_s = 1'b1;
          end else begin
            we_nx_s = 1'b0;
          end
        end else begin
          state_nx_s = ST_EXE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // State, instruction register, pulse outputs and retire counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      ir_r      <= 16'h0000;
      opab_le   <= 1'b0;
      res_le    <= 1'b0;
      rf_we     <= 1'b0;
      done      <= 1'b0;
      instr_cnt <= '0;
    end else begin
      state_r   <= state_nx_s;
      ir_r      <= ir_nx_s;
      opab_le   <= opab_nx_s;
      res_le    <= res_nx_s;
      rf_we     <= we_nx_s;
      done      <= done_nx_s;
      instr_cnt <= cnt_nx_s;
    end
  end

  // Datapath addresses and opcode come from the latched instruction and
  // deliberately persist through IDLE.
  assign alu_op = ir_r[15:12];
  assign rf_ra1 = ir_r[11:8];
  assign rf_ra2 = ir_r[7:4];
  assign rf_wa  = ir_r[3:0];
  assign phase  = state_r;

endmodule

// File: tb/tb_reg_alu_step_ctrl.sv
// Testbench for reg_alu_step_ctrl: instance 0 uses DEB_CYCLES=1/CNT_W=8,
// instance 1 uses DEB_CYCLES=4/CNT_W=2. A reference model tracks the
// instruction phase, latched instruction and retire count per instance.
module tb_reg_alu_step_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        btn_v [2];
  logic [15:0] ins_v [2];
  logic [3:0]  ra1_v [2];
  logic [3:0]  ra2_v [2];
  logic [3:0]  op_v  [2];
  logic [3:0]  wa_v  [2];
  logic        opab_v[2];
  logic        res_v [2];
  logic        we_v  [2];
  logic        done_v[2];
  logic [1:0]  ph_v  [2];
  logic [7:0]  cnt_a;
  logic [1:0]  cnt_b;
  logic [7:0]  cnt_v [2];

  assign cnt_v[0] = cnt_a;
  assign cnt_v[1] = {6'd0, cnt_b};

  reg_alu_step_ctrl #(.DEB_CYCLES(1), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .INS(ins_v[0]), .btn(btn_v[0]),
    .rf_ra1(ra1_v[0]), .rf_ra2(ra2_v[0]), .opab_le(opab_v[0]), .alu_op(op_v[0]),
    .res_le(res_v[0]), .rf_wa(wa_v[0]), .rf_we(we_v[0]), .phase(ph_v[0]),
    .done(done_v[0]), .instr_cnt(cnt_a)
  );

  reg_alu_step_ctrl #(.DEB_CYCLES(4), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .INS(ins_v[1]), .btn(btn_v[1]),
    .rf_ra1(ra1_v[1]), .rf_ra2(ra2_v[1]), .opab_le(opab_v[1]), .alu_op(op_v[1]),
    .res_le(res_v[1]), .rf_wa(wa_v[1]), .rf_we(we_v[1]), .phase(ph_v[1]),
    .done(done_v[1]), .instr_cnt(cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cnt = 0;

  int   opab_n[2]    = '{0, 0};
  int   res_n[2]     = '{0, 0};
  int   we_n[2]      = '{0, 0};
  int   done_n[2]    = '{0, 0};
  int   long_n[2]    = '{0, 0};
  int   last_edge[2] = '{0, 0};
  int   snap_cnt[2]  = '{0, 0};
  logic [3:0] snap_ra1[2] = '{4'd0, 4'd0};
  logic [3:0] snap_ra2[2] = '{4'd0, 4'd0};
  logic [3:0] snap_op[2]  = '{4'd0, 4'd0};
  logic [3:0] snap_wa[2]  = '{4'd0, 4'd0};
  logic p_opab[2] = '{1'b0, 1'b0};
  logic p_res[2]  = '{1'b0, 1'b0};
  logic p_we[2]   = '{1'b0, 1'b0};

  // Reference model state
  logic [15:0] m_ir[2];
  int          m_phase[2];
  int          m_cnt[2];

  // Edge index of the most recent rising clock edge.
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Pulse monitor: counts pulses, snapshots the datapath fields at each one
  // and flags any pulse lasting more than one cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (opab_v[i] === 1'b1) begin
        opab_n[i]    <= opab_n[i] + 1;
        snap_ra1[i]  <= ra1_v[i];
        snap_ra2[i]  <= ra2_v[i];
        last_edge[i] <= edge_cnt;
      end
      if (res_v[i] === 1'b1) begin
        res_n[i]     <= res_n[i] + 1;
        snap_op[i]   <= op_v[i];
        last_edge[i] <= edge_cnt;
      end
      if (we_v[i] === 1'b1) begin
        we_n[i]    <= we_n[i] + 1;
        snap_wa[i] <= wa_v[i];
      end
      if (done_v[i] === 1'b1) begin
        done_n[i]    <= done_n[i] + 1;
        snap_cnt[i]  <= int'(cnt_v[i]);
        last_edge[i] <= edge_cnt;
      end
      if ((opab_v[i] === 1'b1 && p_opab[i] === 1'b1) ||
          (res_v[i] === 1'b1 && p_res[i] === 1'b1) ||
          (we_v[i] === 1'b1 && p_we[i] === 1'b1))
        long_n[i] <= long_n[i] + 1;
      p_opab[i] <= opab_v[i];
      p_res[i]  <= res_v[i];
      p_we[i]   <= we_v[i];
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ir[i]    = 16'h0000;
      m_phase[i] = 0;
      m_cnt[i]   = 0;
    end
  endtask

  // One debounced press on instance sel, btn held for hold cycles.
  task automatic press(input int sel, input int hold);
    int deb, mask, pre, start;
    int o0, r0, w0, d0, eo, er, ew, ed, act, exp_v;
    logic [15:0] ir;
    logic [15:0] flds;
    deb  = (sel == 0) ? 1 : 4;
    mask = (sel == 0) ? 255 : 3;
    pre  = m_phase[sel];
    o0 = opab_n[sel]; r0 = res_n[sel]; w0 = we_n[sel]; d0 = done_n[sel];
    eo = 0; er = 0; ew = 0; ed = 0;
    if (pre == 0) begin
      m_ir[sel] = ins_v[sel];
      m_phase[sel] = 1;
      eo = 1;
    end else if (pre == 1) begin
      m_phase[sel] = 2;
      er = 1;
    end else begin
      m_phase[sel] = 0;
      m_cnt[sel] = (m_cnt[sel] + 1) & mask;
      ed = 1;
      ir = m_ir[sel];
      ew = (ir[15:12] != 4'hF) ? 1 : 0;
    end
    ir = m_ir[sel];
    @(negedge clk);
    btn_v[sel] = 1'b1;
    start = edge_cnt + 1;
    repeat (hold) @(negedge clk);
    btn_v[sel] = 1'b0;
    repeat (deb + 8) @(negedge clk);

    act   = (opab_n[sel]-o0)*1000 + (res_n[sel]-r0)*100 + (we_n[sel]-w0)*10 + (done_n[sel]-d0);
    exp_v = eo*1000 + er*100 + ew*10 + ed;
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL pulse_counts[%0d]: got opab/res/we/done %04d, expected %04d", sel, act, exp_v);
    end
    n_checks++;
    if (last_edge[sel] !== start + deb + 3) begin
      n_fail++;
      $display("FAIL pulse_latency[%0d]: got edge %0d, expected %0d", sel, last_edge[sel], start + deb + 3);
    end
    n_checks++;
    if (int'(ph_v[sel]) !== m_phase[sel]) begin
      n_fail++;
      $display("FAIL phase[%0d]: got %0d, expected %0d", sel, ph_v[sel], m_phase[sel]);
    end
    flds = {op_v[sel], ra1_v[sel], ra2_v[sel], wa_v[sel]};
    n_checks++;
    if (flds !== ir) begin
      n_fail++;
      $display("FAIL held_fields[%0d]: got %h, expected %h", sel, flds, ir);
    end
    n_checks++;
    if (int'(cnt_v[sel]) !== m_cnt[sel]) begin
      n_fail++;
      $display("FAIL instr_cnt[%0d]: got %0d, expected %0d", sel, cnt_v[sel], m_cnt[sel]);
    end
    n_checks++;
    if (long_n[sel] !== 0) begin
      n_fail++;
      $display("FAIL pulse_width[%0d]: got %0d long pulses, expected 0", sel, long_n[sel]);
    end
    if (pre == 0) begin
      n_checks++;
      if ({snap_ra1[sel], snap_ra2[sel]} !== ir[11:4]) begin
        n_fail++;
        $display("FAIL opab_addr[%0d]: got %h, expected %h", sel, {snap_ra1[sel], snap_ra2[sel]}, ir[11:4]);
      end
    end else if (pre == 1) begin
      n_checks++;
      if (snap_op[sel] !== ir[15:12]) begin
        n_fail++;
        $display("FAIL res_op[%0d]: got %h, expected %h", sel, snap_op[sel], ir[15:12]);
      end
    end else begin
      n_checks++;
      if (snap_cnt[sel] !== m_cnt[sel]) begin
        n_fail++;
        $display("FAIL done_cnt[%0d]: got %0d, expected %0d", sel, snap_cnt[sel], m_cnt[sel]);
      end
      if (ew == 1) begin
        n_checks++;
        if (snap_wa[sel] !== ir[3:0]) begin
          n_fail++;
          $display("FAIL we_addr[%0d]: got %h, expected %h", sel, snap_wa[sel], ir[3:0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      n_checks++;
      if ({ra1_v[i], ra2_v[i], op_v[i], wa_v[i], opab_v[i], res_v[i], we_v[i],
           done_v[i], ph_v[i], cnt_v[i]} !== 32'd0) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h, expected 0", i,
                 {ra1_v[i], ra2_v[i], op_v[i], wa_v[i], opab_v[i], res_v[i], we_v[i],
                  done_v[i], ph_v[i], cnt_v[i]});
      end
    end
  endtask

  task automatic test_basic();
    ins_v[0] = 16'h0234;
    repeat (3) press(0, 4);
  endtask

  task automatic test_ins_change();
    ins_v[0] = 16'h1414;
    press(0, 3);
    ins_v[0] = 16'hABCD;
    press(0, 5);
    press(0, 3);
  endtask

  task automatic test_nop();
    ins_v[0] = 16'hF123;
    repeat (3) press(0, 4);
  endtask

  task automatic test_debounce();
    int t0;
    t0 = opab_n[1] + res_n[1] + we_n[1] + done_n[1];
    @(negedge clk);
    btn_v[1] = 1'b1;
    repeat (3) @(negedge clk);
    btn_v[1] = 1'b0;
    repeat (20) @(negedge clk);
    n_checks++;
    if (opab_n[1] + res_n[1] + we_n[1] + done_n[1] !== t0 || ph_v[1] !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch_rejected: got %0d new pulses phase %0d, expected 0 and 0",
               opab_n[1] + res_n[1] + we_n[1] + done_n[1] - t0, ph_v[1]);
    end
    ins_v[1] = 16'h5678;
    press(1, 10);
    press(1, 6);
    press(1, 7);
  endtask

  task automatic test_reset_mid();
    int w0;
    ins_v[0] = 16'h2345;
    press(0, 3);
    press(0, 3);
    w0 = we_n[0];
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (10) @(negedge clk);
    n_checks++;
    if (ph_v[0] !== 2'd0 || cnt_a !== 8'd0 || we_n[0] !== w0) begin
      n_fail++;
      $display("FAIL reset_abort: got phase %0d cnt %0d we %0d, expected 0 0 0",
               ph_v[0], cnt_a, we_n[0] - w0);
    end
    ins_v[0] = 16'h6789;
    repeat (3) press(0, 4);
  endtask

  task automatic test_step_reset_collision();
    int o0;
    o0 = opab_n[0];
    ins_v[0] = 16'h3456;
    @(negedge clk);
    btn_v[0] = 1'b1;
    repeat (4) @(negedge clk);
    btn_v[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (15) @(negedge clk);
    n_checks++;
    if (opab_n[0] !== o0 || ph_v[0] !== 2'd0) begin
      n_fail++;
      $display("FAIL step_during_reset: got %0d opab pulses phase %0d, expected 0 and 0",
               opab_n[0] - o0, ph_v[0]);
    end
  endtask

  task automatic test_wrap();
    for (int n = 0; n < 4; n++) begin
      ins_v[1] = 16'($urandom);
      repeat (3) press(1, 6 + n);
    end
  endtask

  task automatic test_hold();
    ins_v[0] = 16'h4C21;
    press(0, 30);
    press(0, 25);
    press(0, 40);
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int n = 0; n < 24; n++) begin
      for (int s = 0; s < 2; s++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 3) == 0) r[15:12] = 4'hF;
        ins_v[s] = r;
        press(s, ((s == 0) ? 3 : 6) + int'($urandom_range(0, 10)));
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    btn_v[0] = 1'b0;
    btn_v[1] = 1'b0;
    ins_v[0] = 16'h0000;
    ins_v[1] = 16'h0000;
    model_reset();
    test_reset();
    test_basic();
    test_ins_change();
    test_nop();
    test_debounce();
    test_reset_mid();
    test_step_reset_collision();
    test_wrap();
    test_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
